// File: rtl/pipeline_mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory port.
package pipeline_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants that bypassed a waiting fetch; sat forces
// the next arbitration in favour of instruction fetch.
module arb_starve_ctr
  import pipeline_mem_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment so an IF grant always restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported fixed-latency memory between instruction fetch and
// data access: data has priority, a starvation guard eventually forces fetch.
module mem_port_arbiter
  import pipeline_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CntW = clog2(MEM_LAT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CntW-1:0]   latCnt_q, latCnt_d;
  logic              memEn_q, memEn_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;

  logic isIdle;
  logic grantIf;
  logic grantD;
  logic respNow;
  logic starveSat;
  logic starveInc;
  logic starveClr;

  // Grants are gated by rst so the accept pulses drop the instant reset rises.
  always_comb begin
    isIdle  = (state_q == ST_IDLE);
    grantIf = isIdle && !rst && if_req && (!d_req || starveSat);
    grantD  = isIdle && !rst && d_req && !grantIf;
    respNow = (state_q == ST_BUSY) && (latCnt_q == '0);
  end

  always_comb begin
    starveInc = grantD && if_req;
    starveClr = grantIf || (isIdle && !if_req);
  end

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(starveInc),
    .clr(starveClr),
    .sat(starveSat)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    latCnt_d   = latCnt_q;
    memEn_d    = 1'b0;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grantIf || grantD) begin
          state_d    = ST_BUSY;
          owner_d    = grantD ? OWN_D : OWN_IF;
          latCnt_d   = CntW'(MEM_LAT);
          memEn_d    = 1'b1;
          memWe_d    = grantD && d_we;
          memAddr_d  = grantD ? d_addr : if_addr;
          memWdata_d = grantD ? d_wdata : '0;
        end
      end
      ST_BUSY: begin
        if (latCnt_q != '0) begin
          latCnt_d = latCnt_q - CntW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      latCnt_q   <= '0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      latCnt_q   <= latCnt_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  // Responses route to the owner only; stores return zero data as an ack.
  always_comb begin
    if_gnt    = grantIf;
    d_gnt     = grantD;
    if_rvalid = respNow && (owner_q == OWN_IF);
    d_rvalid  = respNow && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !memWe_q) ? mem_rdata : '0;
    mem_en    = memEn_q;
    mem_we    = memWe_q;
    mem_addr  = memAddr_q;
    mem_wdata = memWdata_q;
  end

endmodule
